sdram_init_seq: RTL

SDRAM power-up sequencer and refresh-interval timer. It runs from the SDRAM controller clock and is held in reset until the system reset/PLL stage signals that clocks are stable. After power-up it drives the SDRAM command bus through the JEDEC init sequence (wait, precharge-all, N auto-refreshes, load-mode-register), then asserts `init_done` and hands the bus to the command controller. From then on it raises periodic refresh requests.

---
 rtl/sdram_pkg.sv | 28 ++
 rtl/sdram_ref_timer.sv | 41 ++++
 rtl/sdram_init_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init FSM states, helpers.
package sdram_pkg;

    typedef logic [3:0] sdr_cmd_t;

    // {cs_n, ras_n, cas_n, we_n}
    localparam sdr_cmd_t CMD_INHIBIT      = 4'b1111;
    localparam sdr_cmd_t CMD_NOP          = 4'b0111;
    localparam sdr_cmd_t CMD_PRECHARGE    = 4'b0010;
    localparam sdr_cmd_t CMD_AUTO_REFRESH = 4'b0001;
    localparam sdr_cmd_t CMD_LOAD_MODE    = 4'b0000;

    typedef enum logic [2:0] {
        ST_WAIT_PU    = 3'd0,
        ST_PRECHARGE  = 3'd1,
        ST_WAIT_RP    = 3'd2,
        ST_REFRESH    = 3'd3,
        ST_WAIT_RFC   = 3'd4,
        ST_LOAD_MODE  = 3'd5,
        ST_WAIT_MRD   = 3'd6,
        ST_DONE       = 3'd7
    } init_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic refresh-request timer with req/ack handshake and sticky overrun flag.
module sdram_ref_timer #(
    parameter int unsigned REF_INTERVAL = 780
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ref_ack,
    output logic ref_req,
    output logic ref_overrun
);

    localparam int unsigned CW = $clog2(REF_INTERVAL);

    logic [CW-1:0] cnt;
    logic          wrap;

    always_comb wrap = en && (cnt == CW'(REF_INTERVAL - 1));

    // A wrap always (re)asserts the request; a pending unacked request at wrap is an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            ref_req     <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            if (en) begin
                cnt <= wrap ? '0 : cnt + CW'(1);
            end
            if (wrap) begin
                ref_req <= 1'b1;
            end else if (ref_ack) begin
                ref_req <= 1'b0;
            end
            if (wrap && ref_req && !ref_ack) begin
                ref_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up init sequencer (wait, precharge-all, auto-refreshes, load-mode) plus refresh timer.
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int unsigned T_POWERUP    = 20000,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_RFC        = 7,
    parameter int unsigned T_MRD        = 2,
    parameter int unsigned INIT_REFRESH = 8,
    parameter logic [12:0] MODE_REG     = 13'h0032,
    parameter int unsigned REF_INTERVAL = 780
) (
    input  logic        clk,
    input  logic        rst,
    output logic        sdr_cke,
    output sdr_cmd_t    sdr_cmd,
    output logic [1:0]  sdr_ba,
    output logic [12:0] sdr_addr,
    output logic        init_done,
    output logic        ref_req,
    input  logic        ref_ack,
    output logic        ref_overrun
);

    localparam int unsigned T_MAX = max_u(max_u(T_POWERUP, T_RFC), max_u(T_RP, T_MRD));
    localparam int unsigned WCW   = $clog2(T_MAX) + 1;
    localparam int unsigned RCW   = $clog2(INIT_REFRESH) + 1;

    // Last wait-counter value in each wait state; a wait of zero cycles skips the state.
    localparam int unsigned PU_LAST  = (T_POWERUP > 0) ? T_POWERUP - 1 : 0;
    localparam int unsigned RP_LAST  = (T_RP  > 1) ? T_RP  - 2 : 0;
    localparam int unsigned RFC_LAST = (T_RFC > 1) ? T_RFC - 2 : 0;
    localparam int unsigned MRD_LAST = (T_MRD > 1) ? T_MRD - 2 : 0;

    if ((T_POWERUP < 1) || (T_RP < 1) || (T_RFC < 1) || (T_MRD < 1) ||
        (INIT_REFRESH < 1) || (REF_INTERVAL < 2)) begin : g_param_check
        $error("sdram_init_seq: illegal timing parameters");
    end

    init_state_e      state, state_n;
    logic [WCW-1:0]   wait_cnt, wait_n;
    logic [RCW-1:0]   ref_cnt, ref_cnt_n;
    logic             cke_n;
    sdr_cmd_t         cmd_n;
    logic [1:0]       ba_n;
    logic [12:0]      addr_n;
    logic             done_n;

    // Outputs for the next cycle are decoded from the current state, so WAIT_PU spans cycles 0..P-1.
    always_comb begin
        state_n   = state;
        wait_n    = wait_cnt;
        ref_cnt_n = ref_cnt;
        cke_n     = 1'b1;
        cmd_n     = CMD_NOP;
        ba_n      = 2'b00;
        addr_n    = 13'h0000;
        done_n    = 1'b0;
        case (state)
            ST_WAIT_PU: begin
                if (wait_cnt == WCW'(PU_LAST)) begin
                    wait_n  = '0;
                    state_n = ST_PRECHARGE;
                end else begin
                    wait_n = wait_cnt + WCW'(1);
                end
            end
            ST_PRECHARGE: begin
                cmd_n      = CMD_PRECHARGE;
                addr_n[10] = 1'b1;
                state_n    = (T_RP > 1) ? ST_WAIT_RP : ST_REFRESH;
            end
            ST_WAIT_RP: begin
                if (wait_cnt == WCW'(RP_LAST)) begin
                    wait_n  = '0;
                    state_n = ST_REFRESH;
                end else begin
                    wait_n = wait_cnt + WCW'(1);
                end
            end
            ST_REFRESH: begin
                cmd_n     = CMD_AUTO_REFRESH;
                ref_cnt_n = ref_cnt + RCW'(1);
                if (T_RFC > 1) begin
                    state_n = ST_WAIT_RFC;
                end else begin
                    state_n = (ref_cnt == RCW'(INIT_REFRESH - 1)) ? ST_LOAD_MODE : ST_REFRESH;
                end
            end
            ST_WAIT_RFC: begin
                if (wait_cnt == WCW'(RFC_LAST)) begin
                    wait_n  = '0;
                    state_n = (ref_cnt == RCW'(INIT_REFRESH)) ? ST_LOAD_MODE : ST_REFRESH;
                end else begin
                    wait_n = wait_cnt + WCW'(1);
                end
            end
            ST_LOAD_MODE: begin
                cmd_n   = CMD_LOAD_MODE;
                addr_n  = MODE_REG;
                state_n = (T_MRD > 1) ? ST_WAIT_MRD : ST_DONE;
            end
            ST_WAIT_MRD: begin
                if (wait_cnt == WCW'(MRD_LAST)) begin
                    wait_n  = '0;
                    state_n = ST_DONE;
                end else begin
                    wait_n = wait_cnt + WCW'(1);
                end
            end
            ST_DONE: begin
                done_n = 1'b1;
            end
            default: begin
                state_n = ST_WAIT_PU;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_WAIT_PU;
            wait_cnt  <= '0;
            ref_cnt   <= '0;
            sdr_cke   <= 1'b0;
            sdr_cmd   <= CMD_INHIBIT;
            sdr_ba    <= 2'b00;
            sdr_addr  <= 13'h0000;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_n;
            ref_cnt   <= ref_cnt_n;
            sdr_cke   <= cke_n;
            sdr_cmd   <= cmd_n;
            sdr_ba    <= ba_n;
            sdr_addr  <= addr_n;
            init_done <= done_n;
        end
    end

    sdram_ref_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_ref_timer (
        .clk         (clk),
        .rst         (rst),
        .en          (init_done),
        .ref_ack     (ref_ack),
        .ref_req     (ref_req),
        .ref_overrun (ref_overrun)
    );

endmodule
